// File: rtl/uart_periph_responder.sv
// rtl/uart_periph_responder.sv - memory-mapped UART responder for the CPU peripheral bus
//
// Purpose: zero-wait-state UART register block. Read data is combinational, so the
//    CPU side may tie ReadOK/WriteOK high. TX: byte FIFO feeding a serialiser.
//    RX (optional): synchroniser, deserialiser and one-byte holding register.
//    Registers: 0x0 DATA, 0x4 STATUS, 0x8 BAUD_DIV, 0xC CTRL (only address [3:2] decoded).
// Configuration macro: UART_PERIPH_RX_EN builds the receive path; without it UartRx is
//    ignored, STATUS[5:3] read 0 and DATA reads return 0.
// Ports:
//    CoreClock       in   1   clock, rising edge
//    Reset_n         in   1   asynchronous active-low reset
//    AddressBus_P    in   14  byte address
//    DataWriteBus_P  in   32  write data
//    WriteAssert_P   in   1   write strobe
//    ReadAssert_P    in   1   read strobe (side effects at the edge ending the cycle)
//    DataReadBus_P   out  32  combinational read data
//    UartTx          out  1   serial out, idle high
//    UartRx          in   1   serial in, asynchronous
//    Irq             out  1   registered interrupt request
module uart_periph_responder #(
   parameter int          TX_FIFO_DEPTH = 8,
   parameter logic [15:0] DEFAULT_DIV   = 16'd433
) (
   input  logic        CoreClock,
   input  logic        Reset_n,
   input  logic [13:0] AddressBus_P,
   input  logic [31:0] DataWriteBus_P,
   input  logic        WriteAssert_P,
   input  logic        ReadAssert_P,
   output logic [31:0] DataReadBus_P,
   output logic        UartTx,
   input  logic        UartRx,
   output logic        Irq
);
   localparam int AW = $clog2(TX_FIFO_DEPTH);

   logic [15:0] baudDiv;
   logic [2:0]  ctrl;

   // Address bits outside [3:2] alias onto the four registers.
   logic unusedBits;
   assign unusedBits = ^{AddressBus_P[13:4], AddressBus_P[1:0], DataWriteBus_P[31:16]};

   // ---------------------------------------------------------------- registers
   always_ff @(posedge CoreClock or negedge Reset_n) begin
      if (!Reset_n) begin
         baudDiv <= DEFAULT_DIV;
         ctrl    <= 3'b001;
      end else if (WriteAssert_P) begin
         if (AddressBus_P[3:2] == 2'd2)
            baudDiv <= (DataWriteBus_P[15:0] < 16'd3) ? 16'd3 : DataWriteBus_P[15:0];
         if (AddressBus_P[3:2] == 2'd3)
            ctrl <= DataWriteBus_P[2:0];
      end
   end

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]    fifoMem [TX_FIFO_DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0]   fifoCount;
   logic          fifoFull, fifoEmpty, fifoPush, fifoPop;

   assign fifoFull  = (fifoCount == (AW+1)'(TX_FIFO_DEPTH));
   assign fifoEmpty = (fifoCount == '0);
   // A push while full is dropped even if the TX side pops in the same cycle.
   assign fifoPush  = WriteAssert_P & (AddressBus_P[3:2] == 2'd0) & ~fifoFull;

   always_ff @(posedge CoreClock) begin
      if (fifoPush)
         fifoMem[wrPtr] <= DataWriteBus_P[7:0];
   end

   always_ff @(posedge CoreClock or negedge Reset_n) begin
      if (!Reset_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (fifoPush) wrPtr <= wrPtr + 1'b1;
         if (fifoPop)  rdPtr <= rdPtr + 1'b1;
         fifoCount <= fifoCount + (AW+1)'(fifoPush) - (AW+1)'(fifoPop);
      end
   end

   // ---------------------------------------------------------------- TX FSM
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
   txState_t    txState, txStateNext;
   logic [15:0] txCnt, txCntNext;
   logic [7:0]  txShift, txShiftNext;
   logic [2:0]  txBit, txBitNext;
   logic        txLine, txLineNext;
   logic        txBusy, txBitEnd, txCanStart;

   assign txBusy     = (txState != TX_IDLE);
   assign txBitEnd   = (txCnt == 16'd0);
   assign txCanStart = ctrl[0] & ~fifoEmpty;

   // txCnt is reloaded from baudDiv only at bit boundaries, so a BAUD_DIV write
   // never stretches or truncates the bit in flight.
   always_comb begin
      txStateNext = txState;
      txCntNext   = txCnt;
      txShiftNext = txShift;
      txBitNext   = txBit;
      txLineNext  = txLine;
      fifoPop     = 1'b0;
      if (txBusy && !txBitEnd)
         txCntNext = txCnt - 16'd1;
      case (txState)
         TX_IDLE: begin
            if (txCanStart) begin
               fifoPop     = 1'b1;
               txShiftNext = fifoMem[rdPtr];
               txCntNext   = baudDiv;
               txLineNext  = 1'b0;
               txStateNext = TX_START;
            end
         end
         TX_START: begin
            if (txBitEnd) begin
               txCntNext   = baudDiv;
               txBitNext   = 3'd0;
               txLineNext  = txShift[0];
               txStateNext = TX_DATA;
            end
         end
         TX_DATA: begin
            if (txBitEnd) begin
               txCntNext = baudDiv;
               if (txBit == 3'd7) begin
                  txLineNext  = 1'b1;
                  txStateNext = TX_STOP;
               end else begin
                  txBitNext  = txBit + 3'd1;
                  txLineNext = txShift[txBit + 3'd1];
               end
            end
         end
         TX_STOP: begin
            if (txBitEnd) begin
               txCntNext = baudDiv;
               if (txCanStart) begin
                  // Back-to-back frame: straight into the next start bit.
                  fifoPop     = 1'b1;
                  txShiftNext = fifoMem[rdPtr];
                  txLineNext  = 1'b0;
                  txStateNext = TX_START;
               end else begin
                  txLineNext  = 1'b1;
                  txStateNext = TX_IDLE;
               end
            end
         end
         default: begin
            txLineNext  = 1'b1;
            txStateNext = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge CoreClock or negedge Reset_n) begin
      if (!Reset_n) begin
         txState <= TX_IDLE;
         txCnt   <= '0;
         txShift <= '0;
         txBit   <= '0;
         txLine  <= 1'b1;
      end else begin
         txState <= txStateNext;
         txCnt   <= txCntNext;
         txShift <= txShiftNext;
         txBit   <= txBitNext;
         txLine  <= txLineNext;
      end
   end

   assign UartTx = txLine;

   // ---------------------------------------------------------------- RX path
   logic [7:0] rxByte;
   logic       rxValid, rxOverrun, rxFrameErr;

`ifdef UART_PERIPH_RX_EN
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;
   rxState_t    rxState, rxStateNext;
   logic        rxSync1, rxSync2;
   logic [15:0] rxCnt, rxCntNext;
   logic [7:0]  rxShift, rxShiftNext;
   logic [2:0]  rxBit, rxBitNext;
   logic        rxDone, rxBad, dataRead, statusRead;

   assign dataRead   = ReadAssert_P & (AddressBus_P[3:2] == 2'd0);
   assign statusRead = ReadAssert_P & (AddressBus_P[3:2] == 2'd1);

   always_ff @(posedge CoreClock or negedge Reset_n) begin
      if (!Reset_n) begin
         rxSync1 <= 1'b1;
         rxSync2 <= 1'b1;
      end else begin
         rxSync1 <= UartRx;
         rxSync2 <= rxSync1;
      end
   end

   // RX_IDLE is only entered with the line high, so a low level there is a falling edge.
   always_comb begin
      rxStateNext = rxState;
      rxCntNext   = rxCnt;
      rxShiftNext = rxShift;
      rxBitNext   = rxBit;
      rxDone      = 1'b0;
      rxBad       = 1'b0;
      if (rxState != RX_IDLE && rxState != RX_WAIT && rxCnt != 16'd0)
         rxCntNext = rxCnt - 16'd1;
      case (rxState)
         RX_IDLE: begin
            if (!rxSync2) begin
               // Count down ((BAUD_DIV+1)>>1)-1 so the start re-sample lands half a bit in.
               rxCntNext   = {1'b0, baudDiv[15:1]} + {15'd0, baudDiv[0]} - 16'd1;
               rxStateNext = RX_START;
            end
         end
         RX_START: begin
            if (rxCnt == 16'd0) begin
               if (rxSync2) begin
                  rxStateNext = RX_IDLE;
               end else begin
                  rxCntNext   = baudDiv;
                  rxBitNext   = 3'd0;
                  rxStateNext = RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (rxCnt == 16'd0) begin
               rxShiftNext = {rxSync2, rxShift[7:1]};
               rxCntNext   = baudDiv;
               if (rxBit == 3'd7) rxStateNext = RX_STOP;
               else               rxBitNext   = rxBit + 3'd1;
            end
         end
         RX_STOP: begin
            if (rxCnt == 16'd0) begin
               if (rxSync2) begin
                  rxDone      = 1'b1;
                  rxStateNext = RX_IDLE;
               end else begin
                  rxBad       = 1'b1;
                  rxStateNext = RX_WAIT;
               end
            end
         end
         RX_WAIT: begin
            if (rxSync2) rxStateNext = RX_IDLE;
         end
         default: rxStateNext = RX_IDLE;
      endcase
   end

   always_ff @(posedge CoreClock or negedge Reset_n) begin
      if (!Reset_n) begin
         rxState    <= RX_IDLE;
         rxCnt      <= '0;
         rxShift    <= '0;
         rxBit      <= '0;
         rxByte     <= '0;
         rxValid    <= 1'b0;
         rxOverrun  <= 1'b0;
         rxFrameErr <= 1'b0;
      end else begin
         rxState <= rxStateNext;
         rxCnt   <= rxCntNext;
         rxShift <= rxShiftNext;
         rxBit   <= rxBitNext;
         if (rxDone) rxByte <= rxShift;
         // Set events win over read-clears; a DATA read racing a new byte is no overrun.
         rxValid    <= rxDone | (rxValid & ~dataRead);
         rxOverrun  <= (rxDone & rxValid & ~dataRead) | (rxOverrun & ~statusRead);
         rxFrameErr <= rxBad | (rxFrameErr & ~statusRead);
      end
   end
`else
   logic unusedRx;
   assign unusedRx   = UartRx ^ ReadAssert_P;
   assign rxByte     = 8'd0;
   assign rxValid    = 1'b0;
   assign rxOverrun  = 1'b0;
   assign rxFrameErr = 1'b0;
`endif

   // ---------------------------------------------------------------- read mux / irq
   logic [7:0] statusCount;
   assign statusCount = 8'(fifoCount);

   always_comb begin
      DataReadBus_P = 32'd0;
      case (AddressBus_P[3:2])
         2'd0: DataReadBus_P = {24'd0, rxByte};
         2'd1: DataReadBus_P = {16'd0, statusCount, 2'b00, rxFrameErr, rxOverrun,
                                rxValid, txBusy, fifoEmpty, fifoFull};
         2'd2: DataReadBus_P = {16'd0, baudDiv};
         2'd3: DataReadBus_P = {29'd0, ctrl};
         default: DataReadBus_P = 32'd0;
      endcase
   end

   always_ff @(posedge CoreClock or negedge Reset_n) begin
      if (!Reset_n) Irq <= 1'b0;
      else          Irq <= (ctrl[1] & rxValid) | (ctrl[2] & fifoEmpty & ~txBusy);
   end

endmodule

// File: tb/tb_uart_periph_responder.sv
// tb/tb_uart_periph_responder.sv - directed self-checking bench for uart_periph_responder
`timescale 1ns/1ps
module tb_uart_periph_responder;
   logic        CoreClock = 1'b0;
   logic        Reset_n = 1'b0;
   logic [13:0] AddressBus_P = '0;
   logic [31:0] DataWriteBus_P = '0;
   logic        WriteAssert_P = 1'b0;
   logic        ReadAssert_P = 1'b0;
   logic [31:0] DataReadBus_P;
   logic        UartTx;
   logic        UartRx = 1'b1;
   logic        Irq;

   int testsRun = 0;
   int testsFailed = 0;

   always #5 CoreClock = ~CoreClock;

   uart_periph_responder dut (
      .CoreClock(CoreClock), .Reset_n(Reset_n), .AddressBus_P(AddressBus_P),
      .DataWriteBus_P(DataWriteBus_P), .WriteAssert_P(WriteAssert_P),
      .ReadAssert_P(ReadAssert_P), .DataReadBus_P(DataReadBus_P),
      .UartTx(UartTx), .UartRx(UartRx), .Irq(Irq)
   );

   task automatic busWrite(input logic [13:0] a, input logic [31:0] d);
      @(negedge CoreClock);
      AddressBus_P = a; DataWriteBus_P = d; WriteAssert_P = 1'b1;
      @(negedge CoreClock);
      WriteAssert_P = 1'b0;
   endtask

   task automatic busRead(input logic [13:0] a, output logic [31:0] d);
      @(negedge CoreClock);
      AddressBus_P = a; ReadAssert_P = 1'b1;
      #1 d = DataReadBus_P;
      @(negedge CoreClock);
      ReadAssert_P = 1'b0;
   endtask

   task automatic peek(input logic [13:0] a, output logic [31:0] d);
      AddressBus_P = a;
      #1 d = DataReadBus_P;
   endtask

   // Drives one serial frame at 8 cycles per bit, then 4 idle cycles.
   task automatic sendRx(input logic [7:0] b, input logic stopBit);
      logic [9:0] f;
      f = {stopBit, b, 1'b0};
      @(negedge CoreClock);
      for (int i = 0; i < 10; i++) begin
         UartRx = f[i];
         repeat (8) @(negedge CoreClock);
      end
      UartRx = 1'b1;
      repeat (4) @(negedge CoreClock);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      busWrite(14'h0, 32'h55);
      repeat (20) @(negedge CoreClock);
      testsRun++;
      if (UartTx !== 1'b0) begin testsFailed++; $display("FAIL reset_pre_start: UartTx=%b expected 0", UartTx); end
      #3 Reset_n = 1'b0;
      #1;
      testsRun++;
      if (UartTx !== 1'b1) begin testsFailed++; $display("FAIL reset_tx_async: UartTx=%b expected 1", UartTx); end
      testsRun++;
      if (Irq !== 1'b0) begin testsFailed++; $display("FAIL reset_irq: Irq=%b expected 0", Irq); end
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002) begin testsFailed++; $display("FAIL reset_status: got %h expected 00000002", d); end
      peek(14'h8, d);
      testsRun++;
      if (d !== 32'd433) begin testsFailed++; $display("FAIL reset_baud: got %0d expected 433", d); end
      peek(14'hC, d);
      testsRun++;
      if (d !== 32'h1) begin testsFailed++; $display("FAIL reset_ctrl: got %h expected 1", d); end
      peek(14'h0, d);
      testsRun++;
      if (d !== 32'h0) begin testsFailed++; $display("FAIL reset_data: got %h expected 0", d); end
      repeat (2) @(negedge CoreClock);
      Reset_n = 1'b1;
      repeat (3) @(negedge CoreClock);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002 || UartTx !== 1'b1) begin
         testsFailed++; $display("FAIL reset_release: status=%h tx=%b expected 00000002/1", d, UartTx);
      end
   endtask

   task automatic test_tx_frame();
      logic [9:0] frame;
      logic       expBit;
      frame = {1'b1, 8'hA5, 1'b0};
      busWrite(14'h8, 32'd3);
      busWrite(14'hC, 32'd5);
      busWrite(14'h0, 32'hA5);
      AddressBus_P = 14'h4;
      for (int i = 0; i < 42; i++) begin
         @(negedge CoreClock);
         expBit = (i < 40) ? frame[i/4] : 1'b1;
         testsRun++;
         if (UartTx !== expBit) begin
            testsFailed++; $display("FAIL tx_frame_bit[%0d]: UartTx=%b expected %b", i, UartTx, expBit);
         end
         testsRun++;
         if (Irq !== (i == 41)) begin
            testsFailed++; $display("FAIL tx_irq[%0d]: Irq=%b expected %b", i, Irq, (i == 41));
         end
         if (i == 20) begin
            testsRun++;
            if (DataReadBus_P[2] !== 1'b1) begin
               testsFailed++; $display("FAIL tx_busy: STATUS[2]=%b expected 1", DataReadBus_P[2]);
            end
         end
      end
   endtask

   task automatic test_fifo_back_to_back();
      logic [31:0] d;
      logic [9:0]  got;
      logic [9:0]  expFrame;
      int          lows;
      busWrite(14'hC, 32'd0);
      for (int k = 0; k < 9; k++) busWrite(14'h0, 32'(k));
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0801) begin testsFailed++; $display("FAIL fifo_full_status: got %h expected 00000801", d); end
      busWrite(14'hC, 32'd1);
      got = '0;
      for (int i = 0; i < 320; i++) begin
         @(negedge CoreClock);
         if (i % 4 == 2) got[(i % 40) / 4] = UartTx;
         if (i % 40 == 39) begin
            expFrame = {1'b1, 8'(i / 40), 1'b0};
            testsRun++;
            if (got !== expFrame) begin
               testsFailed++; $display("FAIL b2b_frame[%0d]: got %b expected %b", i / 40, got, expFrame);
            end
         end
      end
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CoreClock);
         if (UartTx !== 1'b1) lows++;
      end
      testsRun++;
      if (lows != 0) begin testsFailed++; $display("FAIL ninth_byte: %0d low cycles expected 0", lows); end
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002) begin testsFailed++; $display("FAIL fifo_drained: got %h expected 00000002", d); end
   endtask

   task automatic test_baud();
      logic [31:0] d;
      logic        idle;
      busWrite(14'h8, 32'd1);
      peek(14'h8, d);
      testsRun++;
      if (d !== 32'd3) begin testsFailed++; $display("FAIL baud_clamp1: got %0d expected 3", d); end
      busWrite(14'h8, 32'd2);
      peek(14'h8, d);
      testsRun++;
      if (d !== 32'd3) begin testsFailed++; $display("FAIL baud_clamp2: got %0d expected 3", d); end
      busWrite(14'h8, 32'hFFFF_0004);
      peek(14'h3FF8, d);
      testsRun++;
      if (d !== 32'd4) begin testsFailed++; $display("FAIL baud_alias: got %h expected 4", d); end
      @(negedge CoreClock);
      AddressBus_P = 14'h8; DataWriteBus_P = 32'd9; WriteAssert_P = 1'b1; ReadAssert_P = 1'b1;
      #1 d = DataReadBus_P;
      @(negedge CoreClock);
      WriteAssert_P = 1'b0; ReadAssert_P = 1'b0;
      testsRun++;
      if (d !== 32'd4) begin testsFailed++; $display("FAIL rw_same_cycle_read: got %0d expected 4", d); end
      peek(14'h8, d);
      testsRun++;
      if (d !== 32'd9) begin testsFailed++; $display("FAIL rw_same_cycle_write: got %0d expected 9", d); end
      busWrite(14'h8, 32'd3);
      busWrite(14'hC, 32'd1);
      busWrite(14'h0, 32'h01);
      busWrite(14'h8, 32'd7);
      repeat (2) @(negedge CoreClock);
      testsRun++;
      if (UartTx !== 1'b0) begin testsFailed++; $display("FAIL baud_start_end: UartTx=%b expected 0", UartTx); end
      @(negedge CoreClock);
      testsRun++;
      if (UartTx !== 1'b1) begin testsFailed++; $display("FAIL baud_start_len: UartTx=%b expected 1", UartTx); end
      repeat (7) @(negedge CoreClock);
      testsRun++;
      if (UartTx !== 1'b1) begin testsFailed++; $display("FAIL baud_new_len: UartTx=%b expected 1", UartTx); end
      @(negedge CoreClock);
      testsRun++;
      if (UartTx !== 1'b0) begin testsFailed++; $display("FAIL baud_bit1: UartTx=%b expected 0", UartTx); end
      idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         @(negedge CoreClock);
         peek(14'h4, d);
         idle = (d[2] == 1'b0);
      end
      testsRun++;
      if (!idle) begin testsFailed++; $display("FAIL baud_frame_timeout: busy=%b expected 0", d[2]); end
   endtask

`ifdef UART_PERIPH_RX_EN
   task automatic test_rx();
      logic [31:0] d;
      busWrite(14'h8, 32'd7);
      busWrite(14'hC, 32'd2);
      sendRx(8'h3C, 1'b1);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_000A) begin testsFailed++; $display("FAIL rx_valid: status=%h expected 0000000a", d); end
      testsRun++;
      if (Irq !== 1'b1) begin testsFailed++; $display("FAIL rx_irq: Irq=%b expected 1", Irq); end
      busRead(14'h0, d);
      testsRun++;
      if (d !== 32'h3C) begin testsFailed++; $display("FAIL rx_data: got %h expected 3c", d); end
      @(negedge CoreClock);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002 || Irq !== 1'b0) begin
         testsFailed++; $display("FAIL rx_clear: status=%h irq=%b expected 00000002/0", d, Irq);
      end
      sendRx(8'h11, 1'b1);
      sendRx(8'h22, 1'b1);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_001A) begin testsFailed++; $display("FAIL rx_overrun: status=%h expected 0000001a", d); end
      busRead(14'h0, d);
      testsRun++;
      if (d !== 32'h22) begin testsFailed++; $display("FAIL rx_overwrite: got %h expected 22", d); end
      busRead(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0012) begin testsFailed++; $display("FAIL rx_status_read: got %h expected 00000012", d); end
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002) begin testsFailed++; $display("FAIL rx_overrun_clear: got %h expected 00000002", d); end
   endtask

   task automatic test_rx_errors();
      logic [31:0] d;
      busWrite(14'hC, 32'd0);
      sendRx(8'h55, 1'b0);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0022) begin testsFailed++; $display("FAIL rx_frame_err: status=%h expected 00000022", d); end
      busRead(14'h4, d);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002) begin testsFailed++; $display("FAIL rx_frame_clear: status=%h expected 00000002", d); end
      @(negedge CoreClock);
      UartRx = 1'b0;
      repeat (2) @(negedge CoreClock);
      UartRx = 1'b1;
      repeat (30) @(negedge CoreClock);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002) begin testsFailed++; $display("FAIL rx_glitch: status=%h expected 00000002", d); end
      sendRx(8'hA5, 1'b1);
      busRead(14'h0, d);
      testsRun++;
      if (d !== 32'hA5) begin testsFailed++; $display("FAIL rx_rearm: got %h expected a5", d); end
   endtask
`else
   task automatic test_rx_disabled();
      logic [31:0] d;
      sendRx(8'h3C, 1'b1);
      sendRx(8'h55, 1'b0);
      peek(14'h4, d);
      testsRun++;
      if (d !== 32'h0000_0002) begin testsFailed++; $display("FAIL rxdis_status: got %h expected 00000002", d); end
      peek(14'h0, d);
      testsRun++;
      if (d !== 32'h0) begin testsFailed++; $display("FAIL rxdis_peek: got %h expected 0", d); end
      busRead(14'h0, d);
      testsRun++;
      if (d !== 32'h0) begin testsFailed++; $display("FAIL rxdis_read: got %h expected 0", d); end
   endtask
`endif

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CoreClock);
      Reset_n = 1'b1;
      repeat (2) @(negedge CoreClock);
      test_reset();
      test_tx_frame();
      test_fifo_back_to_back();
      test_baud();
`ifdef UART_PERIPH_RX_EN
      test_rx();
      test_rx_errors();
`else
      test_rx_disabled();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
